// File: rtl/fifo_sr_pkg.sv
// Shared types and helpers for the shared-resource multi-flux FIFO and its drain stage.
// Round-robin search handles up to 32 fluxes.
package fifo_sr_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FLUX       = 2;

    typedef logic [1:0] buf_cnt_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] idx;
    } rr_t;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    // First set bit of req at or after ptr, wrapping modulo flux.
    function automatic rr_t rr_next(input logic [31:0] req, input logic [5:0] flux,
                                    input logic [4:0] ptr);
        rr_t        r;
        logic [5:0] c;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            c = {1'b0, ptr} + 6'(k);
            if (c >= flux) c = c - flux;
            if (!r.vld && (6'(k) < flux) && req[c[4:0]]) begin
                r.vld = 1'b1;
                r.idx = c[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_sr_drain_if.sv
// FIFO read-port and per-flux output stream bundle for the drain stage.
interface fifo_sr_drain_if import fifo_sr_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FLUX       = DEF_FLUX,
    localparam int TAG_WIDTH = tag_width(FLUX)
);
    logic [FLUX-1:0]                 fifo_empty;
    logic [FLUX-1:0]                 fifo_read;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_dout;
    logic [FLUX-1:0]                 out_valid;
    logic [FLUX-1:0]                 out_ready;
    logic [FLUX*DATA_WIDTH-1:0]      out_data;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_read, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_read, out_valid, out_data
    );
endinterface

// File: rtl/flux_out_buf.sv
// Two-entry per-flux output buffer; head entry is always presented on data.
// Push lands on the next edge; pop on valid & ready; simultaneous push/pop keeps order.
module flux_out_buf import fifo_sr_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output buf_cnt_t              count
);
    logic [DATA_WIDTH-1:0] mem0;
    logic [DATA_WIDTH-1:0] mem1;
    logic                  rd_sel;
    logic                  wr_sel;
    logic                  pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    assign data  = rd_sel ? mem1 : mem0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_sel <= 1'b0;
            wr_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            // The write slot never aliases a valid head while count < 2.
            if (push) begin
                if (wr_sel) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_sel <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_sr_drain.sv
// Round-robin drain of the multi-flux FIFO into per-flux 2-entry valid/ready buffers.
// One-cycle FIFO-to-out_valid latency; a full flux buffer only stalls that flux's reads.
module fifo_sr_drain import fifo_sr_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FLUX       = DEF_FLUX,
    localparam int TAG_WIDTH = tag_width(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drain_en,
    fifo_sr_drain_if.master      bus,
    output logic                 tag_err,
    output logic [TAG_WIDTH-1:0] err_flux
);
    buf_cnt_t             count [FLUX];
    logic [FLUX-1:0]      elig;
    logic [FLUX-1:0]      grant_vec;
    logic [4:0]           rr_ptr;
    rr_t                  pick;
    logic                 grant;
    logic [TAG_WIDTH-1:0] gidx;
    logic [TAG_WIDTH-1:0] dout_tag;

    // Eligibility looks only at the stored count, so out_ready never reaches fifo_read.
    always_comb begin
        elig = '0;
        for (int i = 0; i < FLUX; i++)
            elig[i] = drain_en && !bus.fifo_empty[i] && (count[i] != 2'd2);
    end

    assign pick      = rr_next(32'(elig), 6'(FLUX), rr_ptr);
    assign grant     = pick.vld && !rst;
    assign gidx      = TAG_WIDTH'(pick.idx);
    assign dout_tag  = bus.fifo_dout[DATA_WIDTH +: TAG_WIDTH];
    assign bus.fifo_read = grant_vec;

    for (genvar i = 0; i < FLUX; i++) begin : g_buf
        assign grant_vec[i] = grant && (pick.idx == 5'(i));

        flux_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
            .clk       (clk),
            .rst       (rst),
            .push      (grant_vec[i]),
            .push_data (bus.fifo_dout[DATA_WIDTH-1:0]),
            .valid     (bus.out_valid[i]),
            .ready     (bus.out_ready[i]),
            .data      (bus.out_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .count     (count[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            tag_err  <= 1'b0;
            err_flux <= '0;
        end else if (grant) begin
            rr_ptr <= (pick.idx == 5'(FLUX - 1)) ? 5'd0 : pick.idx + 5'd1;
            // Mismatched words are still delivered; only the first offender is recorded.
            if (dout_tag != gidx) begin
                tag_err <= 1'b1;
                if (!tag_err) err_flux <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_fifo_sr_drain.sv
// Directed vector bench for fifo_sr_drain (FLUX=2, DATA_WIDTH=8): inputs driven on negedge,
// outputs sampled 1ns later, so registered outputs reflect the preceding posedge.
module tb_fifo_sr_drain;
    import fifo_sr_pkg::*;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  empty;
        logic [8:0]  dout;
        logic [1:0]  ready;
        logic [1:0]  e_read;
        logic [1:0]  e_valid;
        logic [15:0] e_data;
        logic        e_terr;
        logic        e_ef;
        logic        data_all;
    } vec_t;

    localparam int NV = 34;

    logic clk;
    logic rst;
    logic drain_en;
    logic tag_err;
    logic err_flux;
    int   checks;
    int   errors;
    vec_t vt [NV];

    fifo_sr_drain_if #(.DATA_WIDTH(8), .FLUX(2)) bus ();

    fifo_sr_drain #(.DATA_WIDTH(8), .FLUX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .drain_en (drain_en),
        .bus      (bus),
        .tag_err  (tag_err),
        .err_flux (err_flux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic en, input logic [1:0] empty,
                                input logic [8:0] dout, input logic [1:0] ready,
                                input logic [1:0] e_read, input logic [1:0] e_valid,
                                input logic [15:0] e_data, input logic e_terr,
                                input logic e_ef, input logic data_all);
        vec_t v;
        v.rst = r; v.en = en; v.empty = empty; v.dout = dout; v.ready = ready;
        v.e_read = e_read; v.e_valid = e_valid; v.e_data = e_data;
        v.e_terr = e_terr; v.e_ef = e_ef; v.data_all = data_all;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, step, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] mask;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drain_en = 1'b0;
        bus.fifo_empty = 2'b11;
        bus.fifo_dout  = '0;
        bus.out_ready  = 2'b00;

        //           rst en empty dout    rdy   read  vld   data      te ef all
        // reset, then alternation between fluxes
        vt[0]  = mk(1, 1, 2'b00, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 0, 1);
        vt[1]  = mk(0, 1, 2'b00, 9'h0A1, 2'b11, 2'b01, 2'b00, 16'h0000, 0, 0, 0);
        vt[2]  = mk(0, 1, 2'b00, 9'h1B1, 2'b11, 2'b10, 2'b01, 16'h00A1, 0, 0, 0);
        vt[3]  = mk(0, 1, 2'b00, 9'h0A2, 2'b11, 2'b01, 2'b10, 16'hB100, 0, 0, 0);
        vt[4]  = mk(0, 1, 2'b00, 9'h1B2, 2'b11, 2'b10, 2'b01, 16'h00A2, 0, 0, 0);
        vt[5]  = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b10, 16'hB200, 0, 0, 0);
        vt[6]  = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 0, 0);
        // backpressure on flux 0 only
        vt[7]  = mk(0, 1, 2'b00, 9'h0A1, 2'b10, 2'b01, 2'b00, 16'h0000, 0, 0, 0);
        vt[8]  = mk(0, 1, 2'b00, 9'h1B1, 2'b10, 2'b10, 2'b01, 16'h00A1, 0, 0, 0);
        vt[9]  = mk(0, 1, 2'b00, 9'h0A2, 2'b10, 2'b01, 2'b11, 16'hB1A1, 0, 0, 0);
        vt[10] = mk(0, 1, 2'b00, 9'h1B2, 2'b10, 2'b10, 2'b01, 16'h00A1, 0, 0, 0);
        vt[11] = mk(0, 1, 2'b00, 9'h1B3, 2'b10, 2'b10, 2'b11, 16'hB2A1, 0, 0, 0);
        vt[12] = mk(0, 1, 2'b00, 9'h1B4, 2'b10, 2'b10, 2'b11, 16'hB3A1, 0, 0, 0);
        vt[13] = mk(0, 1, 2'b00, 9'h1B5, 2'b11, 2'b10, 2'b11, 16'hB4A1, 0, 0, 0);
        vt[14] = mk(0, 1, 2'b00, 9'h0A3, 2'b11, 2'b01, 2'b11, 16'hB5A2, 0, 0, 0);
        vt[15] = mk(0, 1, 2'b10, 9'h0A4, 2'b11, 2'b01, 2'b01, 16'h00A3, 0, 0, 0);
        vt[16] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b01, 16'h00A4, 0, 0, 0);
        vt[17] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 0, 0);
        // tag errors: first on flux 1, then flux 0 must not overwrite err_flux
        vt[18] = mk(0, 1, 2'b01, 9'h055, 2'b11, 2'b10, 2'b00, 16'h0000, 0, 0, 0);
        vt[19] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b10, 16'h5500, 1, 1, 0);
        vt[20] = mk(0, 1, 2'b10, 9'h166, 2'b11, 2'b01, 2'b00, 16'h0000, 1, 1, 0);
        vt[21] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b01, 16'h0066, 1, 1, 0);
        // drain_en drop with buffered data
        vt[22] = mk(0, 1, 2'b00, 9'h1C1, 2'b00, 2'b10, 2'b00, 16'h0000, 1, 1, 0);
        vt[23] = mk(0, 1, 2'b00, 9'h0C2, 2'b00, 2'b01, 2'b10, 16'hC100, 1, 1, 0);
        vt[24] = mk(0, 0, 2'b00, 9'h000, 2'b11, 2'b00, 2'b11, 16'hC1C2, 1, 1, 0);
        vt[25] = mk(0, 0, 2'b00, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 1, 1, 0);
        // fill flux 0 to two entries, then reset mid-stream
        vt[26] = mk(0, 1, 2'b10, 9'h0D1, 2'b00, 2'b01, 2'b00, 16'h0000, 1, 1, 0);
        vt[27] = mk(0, 1, 2'b10, 9'h0D2, 2'b00, 2'b01, 2'b01, 16'h00D1, 1, 1, 0);
        vt[28] = mk(0, 1, 2'b10, 9'h0D3, 2'b00, 2'b00, 2'b01, 16'h00D1, 1, 1, 0);
        vt[29] = mk(1, 1, 2'b00, 9'h0D3, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 1);
        vt[30] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 0, 0);
        vt[31] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b00, 16'h0000, 0, 0, 0);
        vt[32] = mk(0, 1, 2'b00, 9'h0E1, 2'b11, 2'b01, 2'b00, 16'h0000, 0, 0, 0);
        vt[33] = mk(0, 1, 2'b11, 9'h000, 2'b11, 2'b00, 2'b01, 16'h00E1, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst            = vt[i].rst;
            drain_en       = vt[i].en;
            bus.fifo_empty = vt[i].empty;
            bus.fifo_dout  = vt[i].dout;
            bus.out_ready  = vt[i].ready;
            #1;
            mask = vt[i].data_all ? 16'hFFFF
                                  : {{8{vt[i].e_valid[1]}}, {8{vt[i].e_valid[0]}}};
            chk("fifo_read", i, 16'(bus.fifo_read), 16'(vt[i].e_read));
            chk("out_valid", i, 16'(bus.out_valid), 16'(vt[i].e_valid));
            chk("out_data",  i, bus.out_data & mask, vt[i].e_data & mask);
            chk("tag_err",   i, 16'(tag_err), 16'(vt[i].e_terr));
            chk("err_flux",  i, 16'(err_flux), 16'(vt[i].e_ef));
        end

        // Back-to-back words on flux 0 with consumer ready: push and pop every cycle.
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            rst            = 1'b0;
            drain_en       = 1'b1;
            bus.out_ready  = 2'b11;
            bus.fifo_empty = (k < 8) ? 2'b10 : 2'b11;
            bus.fifo_dout  = {1'b0, 8'(8'h10 + k)};
            #1;
            chk("pp_read",  100 + k, 16'(bus.fifo_read), (k < 8) ? 16'h0001 : 16'h0000);
            chk("pp_valid", 100 + k, 16'(bus.out_valid), (k > 0) ? 16'h0001 : 16'h0000);
            if (k > 0)
                chk("pp_data", 100 + k, 16'(bus.out_data[7:0]), 16'(8'h10 + k - 1));
        end
        @(negedge clk);
        bus.fifo_empty = 2'b11;
        #1;
        chk("pp_final_valid", 109, 16'(bus.out_valid), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sr_drain.md
Name: fifo_sr_drain

Overview:
Downstream drain stage for the shared-resource multi-flux FIFO. It watches the FIFO's per-flux empty flags and issues one-hot read strobes under round-robin arbitration. Each returned tagged word has its tag stripped and is steered into a per-flux 2-entry output buffer with a valid/ready handshake. Consumers see FLUX independent streams, and a stalled flux never blocks the others.

Parameters:
DATA_WIDTH, 8, payload width per word
FLUX, 2, number of flows (tags); must be ≥2
TAG_WIDTH, $clog2(FLUX), tag width in the MSBs of the FIFO word (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
drain_en  in  1  when 0, no reads are issued; buffered words still drain
fifo_empty  in  FLUX  per-flux empty flags from the FIFO read port
fifo_read  out  FLUX  one-hot read strobe to the FIFO read port; all-zero means no read
fifo_dout  in  DATA_WIDTH+TAG_WIDTH  word for the currently strobed flux, combinational in the same cycle; tag in the MSBs
out_valid  out  FLUX  per-flux output valid
out_ready  in  FLUX  per-flux consumer ready
out_data  out  FLUX*DATA_WIDTH  flattened payloads; flux i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
tag_err  out  1  sticky: a returned tag did not match the strobed flux
err_flux  out  TAG_WIDTH  flux index at the first tag error

Behaviour:
- Reset (async): all buffer counts 0; out_valid=0; out_data=0; round-robin pointer=0; tag_err=0; err_flux=0. fifo_read is forced to 0 combinationally while rst=1.
- Flux i is eligible when drain_en=1, fifo_empty[i]=0 and buf_count[i]<2. Outputs are never popped speculatively to make room.
- Arbitration: at most one grant per cycle. Search starts at rr_ptr and wraps modulo FLUX. On a grant to g, rr_ptr <= (g+1) mod FLUX; with no grant rr_ptr holds.
- fifo_read = onehot(g) in the grant cycle, otherwise 0. Never more than one bit set.
- Capture: in grant cycle N, fifo_dout[DATA_WIDTH-1:0] is written into buffer g at the posedge ending N. out_valid[g] is 1 from cycle N+1 if the buffer was empty. Latency empty-FIFO-word to out_valid is 1 cycle.
- Per-flux buffer is a 2-entry FIFO. out_data shows the head entry; a pop happens when out_valid[i]&out_ready[i].
- A push and a pop in the same cycle are allowed: count unchanged, order preserved. A push with count=2 cannot occur (eligibility rule).
- Throughput: a single flux with out_ready held at 1 sustains one word per cycle.
- out_valid/out_data are stable while out_valid=1 and out_ready=0 (AXI-style rule). out_ready has no combinational path to fifo_read.
- Tag check: if fifo_dout[MSB -: TAG_WIDTH] ≠ g at a grant, tag_err <= 1. err_flux <= g only when tag_err was 0. The word is still delivered to flux g. The error clears only on rst.
- drain_en falling mid-stream: reads stop the same cycle; buffered words keep draining.
- Reset asserted mid-transfer: buffered words are discarded. A word whose strobe coincided with rst is not captured; the FIFO is reset by the same rst.

Decomposition:
- Package fifo_sr_pkg holds:
  - TAG_WIDTH derivation function (clog2 with minimum 1)
  - rr_next function (round-robin search returning index and valid)
  - typedef of the buffer count type (2 bits)
  - shared defaults for DATA_WIDTH and FLUX, reused by the FIFO and its writer
- One sub-module, flux_out_buf: the 2-entry valid/ready buffer with push/pop and count. It is instantiated FLUX times in a generate loop.
- The arbiter, tag check and error logic live in the top.

Test Plan (FLUX=2, DATA_WIDTH=8):
- Reset: rst held high while fifo_empty=2'b00 → fifo_read=0, out_valid=0, tag_err=0. After release, the first read is 2'b01.
- Alternation: both fluxes non-empty, out_ready=2'b11 → fifo_read sequence 01,10,01,10. Words {tag0,0xA1},{tag1,0xB1} appear on out_data[7:0]=0xA1 and out_data[15:8]=0xB1, each one cycle after its strobe.
- Backpressure isolation: out_ready[0]=0 with flux 0 supplying 4 words → exactly 2 reads to flux 0, then flux 0 is ineligible. Flux 1 keeps reading every cycle. Raising out_ready[0] drains 0xA1 then 0xA2 in order, and reads to flux 0 resume.
- Simultaneous push/pop: flux 0 count=1, out_ready[0]=1, grant to flux 0 → count stays 1 and order is preserved across 8 back-to-back words 0x10..0x17.
- Tag error: strobe flux 1 while fifo_dout tag=0, payload 0x55 → tag_err=1 and err_flux=1 next cycle, 0x55 delivered on flux 1. A later mismatch on flux 0 leaves err_flux=1.
- drain_en and mid-reset: drop drain_en with data pending → fifo_read=0 immediately while buffers empty out. Assert rst with count=2 → out_valid=0 asynchronously, and no stale word appears after release.
